// File: rtl/cpu_run_ctrl_pkg.sv
// Shared constants for the run/halt/step controller of the single-cycle core.
package cpu_ctrl_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned STATE_W = 2;

    // FSM state encoding, also driven straight onto the status LEDs
    localparam logic [1:0] ST_RESET = 2'd0;
    localparam logic [1:0] ST_HALT  = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_STEP  = 2'd3;

    // Defaults for a 100 MHz board clock: 10 Hz execution, 10 ms debounce
    localparam int unsigned DEF_DIV       = 10_000_000;
    localparam int unsigned DEF_DEBOUNCE  = 1_000_000;
    localparam int unsigned DEF_RST_TICKS = 4;

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Board-facing bundle: buttons, breakpoint setup and core control/status.
interface cpu_run_ctrl_if;
    import cpu_ctrl_pkg::*;

    logic                btn_run;
    logic                btn_step;
    logic                btn_rst;
    logic [XLEN-1:0]     pc;
    logic [XLEN-1:0]     bp_addr;
    logic                bp_en;
    logic                cpu_ce;
    logic                cpu_reset;
    logic [STATE_W-1:0]  state;
    logic [XLEN-1:0]     instr_count;

    // Board / environment side
    modport master (
        output btn_run, btn_step, btn_rst, pc, bp_addr, bp_en,
        input  cpu_ce, cpu_reset, state, instr_count
    );

    // Controller side
    modport slave (
        input  btn_run, btn_step, btn_rst, pc, bp_addr, bp_en,
        output cpu_ce, cpu_reset, state, instr_count
    );

endinterface

// File: rtl/cpu_run_ctrl_btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability filter, press pulse.
module btn_debounce #(
    parameter int unsigned DEBOUNCE = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam int unsigned CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    logic             sync_q1;
    logic             sync_q2;
    logic [CNT_W-1:0] stab_cnt;

    // Bring the raw button into the clk domain
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= btn_raw;
            sync_q2 <= sync_q1;
        end
    end

    // Accept a new level after DEBOUNCE consecutive differing samples; pulse on rising accept
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stab_cnt <= '0;
            level    <= 1'b0;
            press    <= 1'b0;
        end else if (sync_q2 != level) begin
            if (stab_cnt == CNT_W'(DEBOUNCE - 1)) begin
                stab_cnt <= '0;
                level    <= sync_q2;
                press    <= sync_q2;
            end else begin
                stab_cnt <= stab_cnt + CNT_W'(1);
                press    <= 1'b0;
            end
        end else begin
            stab_cnt <= '0;
            press    <= 1'b0;
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/halt/single-step/breakpoint sequencer producing the core's clock enable and reset.
module cpu_run_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned DIV       = DEF_DIV,
    parameter int unsigned DEBOUNCE  = DEF_DEBOUNCE,
    parameter int unsigned RST_TICKS = DEF_RST_TICKS
) (
    input  logic          clk,
    input  logic          reset_n,
    cpu_run_ctrl_if.slave bus
);

    localparam int unsigned DIV_W = $clog2(DIV);
    localparam int unsigned RST_W = (RST_TICKS > 1) ? $clog2(RST_TICKS) : 1;

    logic [DIV_W-1:0]   tick_cnt;
    logic               tick;

    logic               run_press;
    logic               step_press;
    logic               rst_press;
    logic               run_level;
    logic               step_level;
    logic               rst_level;
    logic               unused_levels;

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_nx;
    logic [RST_W-1:0]   rst_cnt;
    logic [RST_W-1:0]   rst_cnt_nx;
    logic               resume;
    logic               resume_nx;
    logic               cpu_reset;
    logic               cpu_ce_c;
    logic               bp_hit;
    logic [XLEN-1:0]    instr_count;

    btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_run (
        .clk     (clk),
        .reset_n (reset_n),
        .btn_raw (bus.btn_run),
        .level   (run_level),
        .press   (run_press)
    );

    btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_step (
        .clk     (clk),
        .reset_n (reset_n),
        .btn_raw (bus.btn_step),
        .level   (step_level),
        .press   (step_press)
    );

    btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_rst (
        .clk     (clk),
        .reset_n (reset_n),
        .btn_raw (bus.btn_rst),
        .level   (rst_level),
        .press   (rst_press)
    );

    // Only the press edges matter here; the held levels are not needed
    assign unused_levels = run_level & step_level & rst_level;

    assign tick   = (tick_cnt == DIV_W'(DIV - 1));
    assign bp_hit = bus.bp_en && (bus.pc == bus.bp_addr);

    // Free-running execution tick divider, independent of the FSM
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + DIV_W'(1);
        end
    end

    // Next state and clock-enable; press inputs are flop outputs so cpu_ce stays glitch-free
    always_comb begin
        state_nx   = state;
        rst_cnt_nx = rst_cnt;
        resume_nx  = resume;
        cpu_ce_c   = 1'b0;

        case (state)
            ST_RESET: begin
                if (tick) begin
                    if (rst_cnt == RST_W'(RST_TICKS - 1)) begin
                        state_nx   = ST_HALT;
                        rst_cnt_nx = '0;
                    end else begin
                        rst_cnt_nx = rst_cnt + RST_W'(1);
                    end
                end
            end
            ST_HALT: begin
                if (run_press) begin
                    state_nx  = ST_RUN;
                    resume_nx = 1'b1;
                end else if (step_press) begin
                    state_nx = ST_STEP;
                end
            end
            ST_STEP: begin
                if (run_press) begin
                    state_nx = ST_HALT;
                end else if (tick) begin
                    cpu_ce_c = 1'b1;
                    state_nx = ST_HALT;
                end
            end
            ST_RUN: begin
                if (run_press) begin
                    state_nx = ST_HALT;
                end else if (tick) begin
                    if (bp_hit && !resume) begin
                        state_nx = ST_HALT;
                    end else begin
                        cpu_ce_c  = 1'b1;
                        resume_nx = 1'b0;
                    end
                end
            end
            default: begin
                state_nx = ST_RESET;
            end
        endcase

        // Re-reset beats every other event, including a coincident tick
        if (rst_press) begin
            state_nx   = ST_RESET;
            rst_cnt_nx = '0;
            cpu_ce_c   = 1'b0;
        end
    end

    // FSM registers; cpu_reset follows the state so it drops exactly on entering HALT
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_RESET;
            rst_cnt   <= '0;
            resume    <= 1'b0;
            cpu_reset <= 1'b1;
        end else begin
            state     <= state_nx;
            rst_cnt   <= rst_cnt_nx;
            resume    <= resume_nx;
            cpu_reset <= (state_nx == ST_RESET);
        end
    end

    // Retired-instruction counter, cleared on re-reset, wraps naturally
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instr_count <= '0;
        end else if (rst_press) begin
            instr_count <= '0;
        end else if (cpu_ce_c) begin
            instr_count <= instr_count + XLEN'(1);
        end
    end

    assign bus.cpu_ce      = cpu_ce_c;
    assign bus.cpu_reset   = cpu_reset;
    assign bus.state       = state;
    assign bus.instr_count = instr_count;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scenario bench for cpu_run_ctrl with a cpu_ce scoreboard (DIV=4, DEBOUNCE=3, RST_TICKS=2).
module tb_cpu_run_ctrl;

    localparam int unsigned DIV       = 4;
    localparam int unsigned DEBOUNCE  = 3;
    localparam int unsigned RST_TICKS = 2;

    localparam logic [1:0] S_RESET = 2'd0;
    localparam logic [1:0] S_HALT  = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_STEP  = 2'd3;

    typedef struct {
        int          cyc;
        logic [31:0] cnt;
    } exp_t;

    logic        clk;
    logic        reset_n;
    int          cyc;
    int          checks;
    int          errors;
    logic [31:0] model_cnt;
    exp_t        exp_q[$];

    cpu_run_ctrl_if bus();

    cpu_run_ctrl #(
        .DIV       (DIV),
        .DEBOUNCE  (DEBOUNCE),
        .RST_TICKS (RST_TICKS)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle index since reset release: cycle k ends at the k-th rising edge
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    // Scoreboard: every observed cpu_ce must match the next expected pulse
    always @(negedge clk) begin
        if (reset_n && bus.cpu_ce !== 1'b0) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ce cyc=%0d ce=%b count=%h", cyc, bus.cpu_ce, bus.instr_count);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (cyc !== e.cyc || bus.instr_count !== e.cnt || bus.cpu_reset !== 1'b0) begin
                    errors++;
                    $display("FAIL ce_pulse got cyc=%0d count=%h rst=%b want cyc=%0d count=%h rst=0",
                             cyc, bus.instr_count, bus.cpu_reset, e.cyc, e.cnt);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    function automatic int next_tick(int from);
        int t;
        t = from;
        while ((t % DIV) != (DIV - 1)) t++;
        return t;
    endfunction

    task automatic expect_ce(int t);
        exp_q.push_back('{t, model_cnt});
        model_cnt = model_cnt + 32'd1;
    endtask

    task automatic wait_until(int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic check_state(string name, logic [1:0] want);
        checks++;
        if (bus.state !== want) begin
            errors++;
            $display("FAIL %s state got %0d want %0d (cyc %0d)", name, bus.state, want, cyc);
        end
    endtask

    task automatic check_count(string name, logic [31:0] want);
        checks++;
        if (bus.instr_count !== want) begin
            errors++;
            $display("FAIL %s instr_count got %h want %h (cyc %0d)", name, bus.instr_count, want, cyc);
        end
    endtask

    task automatic check_rst(string name, logic want);
        checks++;
        if (bus.cpu_reset !== want) begin
            errors++;
            $display("FAIL %s cpu_reset got %b want %b (cyc %0d)", name, bus.cpu_reset, want, cyc);
        end
    endtask

    task automatic check_queue_empty(string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s missing_ce got %0d pending want 0 (next cyc %0d)", name, exp_q.size(), exp_q[0].cyc);
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        reset_n         = 1'b0;
        bus.btn_run     = 1'b0;
        bus.btn_step    = 1'b0;
        bus.btn_rst     = 1'b0;
        bus.pc          = 32'h0;
        bus.bp_addr     = 32'h0;
        bus.bp_en       = 1'b0;
        model_cnt       = 32'h0;
        repeat (3) @(negedge clk);
        check_state("reset_hold", S_RESET);
        check_rst("reset_hold", 1'b1);
        check_count("reset_hold", 32'h0);
        checks++;
        if (bus.cpu_ce !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold cpu_ce got %b want 0", bus.cpu_ce);
        end
        reset_n = 1'b1;
        wait_until(7);
        check_state("reset_tick2", S_RESET);
        check_rst("reset_tick2", 1'b1);
        wait_until(8);
        check_state("reset_exit", S_HALT);
        check_rst("reset_exit", 1'b0);
        check_count("reset_exit", 32'h0);
    endtask

    task automatic test_run_halt();
        int c, t0;
        repeat (2) @(negedge clk);
        c  = cyc;
        t0 = next_tick(c + 6);
        for (int k = 0; k < 5; k++) expect_ce(t0 + 4 * k);
        bus.btn_run = 1'b1;
        wait_until(c + 6);
        check_state("run_enter", S_RUN);
        wait_until(c + 10);
        bus.btn_run = 1'b0;
        // Halt press pulse lands exactly on the tick at t0+20, which must be swallowed
        wait_until(t0 + 15);
        bus.btn_run = 1'b1;
        wait_until(t0 + 20);
        check_state("halt_press_cycle", S_RUN);
        wait_until(t0 + 21);
        check_state("halt_after_run", S_HALT);
        check_count("halt_after_run", model_cnt);
        wait_until(t0 + 23);
        bus.btn_run = 1'b0;
        wait_until(t0 + 30);
        check_state("halt_stays", S_HALT);
        check_count("halt_stays", model_cnt);
        check_queue_empty("run_halt");
    endtask

    task automatic test_breakpoint();
        int c, t1, c2, r0;
        repeat (6) @(negedge clk);
        bus.bp_en   = 1'b1;
        bus.bp_addr = 32'h10;
        bus.pc      = 32'h0;
        c  = cyc;
        t1 = next_tick(c + 6);
        expect_ce(t1);
        bus.btn_run = 1'b1;
        wait_until(c + 8);
        bus.btn_run = 1'b0;
        wait_until(t1);
        bus.pc = 32'h10;
        wait_until(t1 + 4);
        check_state("bp_tick", S_RUN);
        wait_until(t1 + 5);
        check_state("bp_stop", S_HALT);
        check_count("bp_stop", model_cnt);
        check_queue_empty("bp_stop");
        // Resume from the breakpoint PC: first tick executes; re-reset arrives before the next tick
        repeat (6) @(negedge clk);
        c2 = cyc;
        r0 = next_tick(c2 + 6);
        expect_ce(r0);
        bus.btn_run = 1'b1;
        wait_until(r0 - 3);
        bus.btn_rst = 1'b1;
        wait_until(c2 + 8);
        bus.btn_run = 1'b0;
        wait_until(r0);
        bus.pc = 32'h14;
        check_state("bp_resume", S_RUN);
        wait_until(r0 + 2);
        check_count("rst_in_run_before", 32'd7);
        model_cnt = 32'h0;
        wait_until(r0 + 3);
        check_state("rst_in_run", S_RESET);
        check_rst("rst_in_run", 1'b1);
        check_count("rst_in_run", 32'h0);
        wait_until(r0 + 5);
        bus.btn_rst = 1'b0;
        wait_until(r0 + 8);
        check_state("rst_second_tick", S_RESET);
        wait_until(r0 + 9);
        check_state("rst_exit", S_HALT);
        check_rst("rst_exit", 1'b0);
        check_queue_empty("breakpoint");
    endtask

    task automatic test_step();
        int c, t;
        logic saw_step;
        repeat (6) @(negedge clk);
        bus.pc = 32'h10;
        c = cyc;
        t = next_tick(c + 6);
        expect_ce(t);
        bus.btn_step = 1'b1;
        wait_until(c + 6);
        check_state("step_enter", S_STEP);
        wait_until(c + 10);
        bus.btn_step = 1'b0;
        check_state("step_done", S_HALT);
        check_count("step_done", model_cnt);
        check_queue_empty("step");
        // Two-cycle glitch must not be accepted as a press
        wait_until(c + 16);
        bus.btn_step = 1'b1;
        repeat (2) @(negedge clk);
        bus.btn_step = 1'b0;
        saw_step = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.state === S_STEP) saw_step = 1'b1;
        end
        checks++;
        if (saw_step !== 1'b0) begin
            errors++;
            $display("FAIL step_glitch entered STEP got %b want 0", saw_step);
        end
        check_count("step_glitch", model_cnt);
    endtask

    task automatic test_coincident_press();
        int c, ta;
        repeat (4) @(negedge clk);
        c  = cyc;
        ta = next_tick(c + 6);
        bus.btn_run = 1'b1;
        bus.btn_rst = 1'b1;
        model_cnt   = 32'h0;
        wait_until(c + 6);
        check_state("coincide", S_RESET);
        check_rst("coincide", 1'b1);
        check_count("coincide", 32'h0);
        wait_until(c + 8);
        bus.btn_run = 1'b0;
        bus.btn_rst = 1'b0;
        wait_until(ta + 4);
        check_state("coincide_tick2", S_RESET);
        wait_until(ta + 5);
        check_state("coincide_exit", S_HALT);
    endtask

    task automatic test_overflow();
        int c, t;
        repeat (6) @(negedge clk);
        force dut.instr_count = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk);
        release dut.instr_count;
        model_cnt = 32'hFFFF_FFFF;
        @(negedge clk);
        check_count("preload", 32'hFFFF_FFFF);
        c = cyc;
        t = next_tick(c + 6);
        expect_ce(t);
        bus.btn_step = 1'b1;
        wait_until(c + 10);
        bus.btn_step = 1'b0;
        wait_until(t + 1);
        check_count("wrap", 32'h0);
        check_state("wrap", S_HALT);
        check_queue_empty("overflow");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_run_halt();
        test_breakpoint();
        test_step();
        test_coincident_press();
        test_overflow();
        repeat (8) @(negedge clk);
        check_queue_empty("final");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
- Run/halt/single-step controller for the single-cycle RISC-V core on the FPGA board.
- Replaces the free-running divided processor clock with a clock-enable tick on the board clock.
- Sequences processor reset, continuous run, single-step and a PC breakpoint from debounced push-buttons.
- Outputs feed the core's clock enable and reset; status goes to LEDs.

Parameters:
- DIV, 10000000, board-clock cycles per execution tick (10 Hz at 100 MHz); minimum 2.
- DEBOUNCE, 1000000, consecutive stable cycles required to accept a button level; minimum 1.
- RST_TICKS, 4, ticks for which cpu_reset is held in RESET; minimum 1.

Ports:
- clk  in  1  board clock.
- reset_n  in  1  asynchronous active-low reset.
- btn_run  in  1  raw button; each press toggles run/halt.
- btn_step  in  1  raw button; each press executes one instruction while halted.
- btn_rst  in  1  raw button; each press re-resets the core.
- pc  in  32  core's current PC.
- bp_addr  in  32  breakpoint address.
- bp_en  in  1  breakpoint enable.
- cpu_ce  out  1  one-clk-wide enable; the core advances one instruction per asserted cycle.
- cpu_reset  out  1  active-high synchronous reset to the core.
- state  out  2  encoding: 0 RESET, 1 HALT, 2 RUN, 3 STEP.
- instr_count  out  32  number of cpu_ce pulses since the last RESET.

Behaviour:
- Async reset (reset_n=0):
  - state=RESET, cpu_reset=1, cpu_ce=0, instr_count=0.
  - Tick counter=0, reset-tick counter=0, debouncers cleared to the released state.
- Tick generator:
  - Free-running counter 0..DIV-1; tick=1 in the cycle the counter equals DIV-1, then wraps to 0.
  - Never restarted by FSM transitions.
- Button path, per button:
  - 2-FF synchronizer, then a stability counter.
  - Accepted level changes only after DEBOUNCE consecutive equal synchronized samples.
  - A one-cycle press pulse is produced on an accepted 0->1 change.
  - Press latency is 2+DEBOUNCE cycles. A release produces no pulse.
- FSM (registered):
  - RESET: cpu_reset=1, cpu_ce=0, instr_count held at 0. Counts ticks; on the RST_TICKS-th tick -> HALT, and cpu_reset drops the same cycle the state becomes HALT.
  - HALT: cpu_ce=0. run pulse -> RUN with resume flag set. step pulse -> STEP.
  - STEP: waits for the next tick, asserts cpu_ce for exactly that cycle, then -> HALT. The breakpoint is ignored in STEP.
  - RUN: normally cpu_ce=tick.
    - Breakpoint stop: on a tick with bp_en=1, pc==bp_addr and resume=0, cpu_ce stays 0 and state -> HALT.
    - resume clears after the first cpu_ce pulse in RUN, so a run from a breakpoint PC executes past it.
    - run pulse -> HALT, and any tick in that same cycle is suppressed.
- Priority when events coincide: btn_rst pulse > run pulse > breakpoint > step pulse.
  - btn_rst pulse from any state -> RESET, clearing the reset-tick counter and instr_count. A re-press in RESET restarts the count.
  - step pulse in RUN or RESET is ignored. A run pulse in STEP -> HALT without executing.
- cpu_ce outputs:
  - cpu_ce is combinational from state and tick, free of button-pulse glitches.
  - cpu_ce is never 1 while cpu_reset=1.
  - At most one cpu_ce per DIV cycles.
- instr_count increments on every cpu_ce and wraps 0xFFFFFFFF -> 0.
- Reset mid-operation: reset_n low at any point overrides everything immediately.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - State encoding constants ST_RESET=0, ST_HALT=1, ST_RUN=2, ST_STEP=3.
  - Default DIV/DEBOUNCE values for a 100 MHz board clock.
- One sub-module, btn_debounce, instantiated three times. It has parameter DEBOUNCE; ports clk, reset_n, btn_raw, level, press.
- Tick generator, FSM and counter live in cpu_run_ctrl.

Test Plan (DIV=4, DEBOUNCE=3, RST_TICKS=2):
- Release reset_n, no buttons -> cpu_reset=1 through the 2nd tick (clk 7), state=HALT at clk 8, cpu_ce never 1, instr_count=0.
- In HALT, hold btn_step high 10 cycles -> exactly one cpu_ce on the next tick after the press pulse, instr_count=1, state back to HALT. A 2-cycle glitch on btn_step -> no pulse.
- Press btn_run -> cpu_ce every 4th cycle. Press again after 5 pulses -> state=HALT, instr_count=5, no further cpu_ce.
- Breakpoint:
  - Set bp_en=1, bp_addr=0x10, drive pc=0x10 while running -> state=HALT on that tick, with no cpu_ce that cycle.
  - Press run again with pc still 0x10 -> first tick gives cpu_ce=1, then normal running.
- Press btn_rst while RUN with instr_count=7 -> state=RESET, cpu_reset=1, instr_count=0. Return to HALT after 2 ticks.
- Coincidence and overflow:
  - Run and rst press pulses in the same cycle -> RESET wins.
  - Preload instr_count to 0xFFFFFFFF via force, then one step -> 0x00000000.
